// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide sequencer: op encoding,
// controller states and the default operand width.
package mips_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } md_state_t;

  // The encoding puts the op class in bit 1 and "unsigned" in bit 0.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_is_div,
  output logic [2*WIDTH:0] o_acc_next
);

  // Accumulator layout: upper WIDTH+1 bits hold the partial product or the
  // running remainder, lower WIDTH bits hold the multiplier or quotient.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH:0] w_shl;

  always_comb begin
    w_sum      = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
    w_shl      = {i_acc[2*WIDTH-1:0], 1'b0};
    w_trial    = w_shl[2*WIDTH:WIDTH] - {1'b0, i_operand};
    o_acc_next = {1'b0, w_sum, i_acc[WIDTH-1:1]};
    if (i_is_div) begin
      if (w_shl[2*WIDTH:WIDTH] >= {1'b0, i_operand}) begin
        o_acc_next = {w_trial, w_shl[WIDTH-1:1], 1'b1};
      end else begin
        o_acc_next = w_shl;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall
// outputs. Optional macro MULDIV_ZERO_SKIP_EN skips CALC for zero operands.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ID_mfhilo,
  input  logic             ID_muldiv,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             pc_stall,
  output logic             IFID_stall,
  output logic             IDEX_flush
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          r_state;
  md_state_t          w_state_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic [2*WIDTH:0]   r_acc;
  logic [2*WIDTH:0]   w_acc_step;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_skip;
  logic               w_dep;
  logic               w_stall;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_a_neg = op_is_signed(op) & a[WIDTH-1];
  assign w_b_neg = op_is_signed(op) & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

`ifdef MULDIV_ZERO_SKIP_EN
  assign w_skip = op_is_div(op) ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign w_skip = 1'b0;
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acc      (r_acc),
    .i_operand  (r_opnd),
    .i_is_div   (r_is_div),
    .o_acc_next (w_acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SIGN already presents the final result through the bypass, so the stall
  // releases there even though busy is still high.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == SIGN);
    w_dep        = ID_mfhilo | ID_muldiv;
    w_stall      = w_dep & ((r_state == CALC) | start);
    case (r_state)
      IDLE:    if (start) w_state_next = w_skip ? SIGN : CALC;
      CALC:    if (r_cnt == CW'(WIDTH - 1)) w_state_next = SIGN;
      SIGN:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign pc_stall   = w_stall;
  assign IFID_stall = w_stall;
  assign IDEX_flush = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= op_is_div(op);
            r_a      <= a;
            r_opnd   <= w_b_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= op_is_div(op) && (b == '0);
            r_acc    <= w_skip ? '0 : {{(WIDTH+1){1'b0}}, w_a_mag};
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CW'(1);
        end
        SIGN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero returns the raw dividend in HI regardless of sign handling.
  always_comb begin
    w_prod   = r_acc[2*WIDTH-1:0];
    w_quo    = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_is_div) begin
      if (r_div0) begin
        w_res_lo = '1;
        w_res_hi = r_a;
      end else begin
        w_res_lo = r_neg_q ? (~w_quo + 1'b1) : w_quo;
        w_res_hi = r_neg_r ? (~w_rem + 1'b1) : w_rem;
      end
    end else begin
      {w_res_hi, w_res_lo} = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    end
  end

  assign hi = done ? w_res_hi : r_hi;
  assign lo = done ? w_res_lo : r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: randomized and directed mult/div traffic
// against an arithmetic reference model, with per-cycle busy/stall checks.
module tb_muldiv_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ID_mfhilo = 1'b0;
  logic          ID_muldiv = 1'b0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          pc_stall;
  logic          IFID_stall;
  logic          IDEX_flush;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .ID_mfhilo  (ID_mfhilo),
    .ID_muldiv  (ID_muldiv),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .pc_stall   (pc_stall),
    .IFID_stall (IFID_stall),
    .IDEX_flush (IDEX_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           m_s = -100;
  int           m_d = -100;
  logic [W-1:0] reg_hi = '0;
  logic [W-1:0] reg_lo = '0;
  logic         chk_en = 1'b0;

  function automatic void model(input logic [1:0] o, input logic [W-1:0] x_in,
                                input logic [W-1:0] y_in,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    longint x, y, p, qq, rr;
    if (o[0]) begin
      x = longint'(x_in);
      y = longint'(y_in);
    end else begin
      x = longint'($signed(x_in));
      y = longint'($signed(y_in));
    end
    if (!o[1]) begin
      p   = x * y;
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (y_in == '0) begin
      rlo = '1;
      rhi = x_in;
    end else begin
      qq  = x / y;
      rr  = x % y;
      rlo = qq[31:0];
      rhi = rr[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   lat;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (!rst && !(cyc > m_s && cyc <= m_d)) begin
      model(o, x, y, e.hi, e.lo);
      lat = W + 1;
`ifdef MULDIV_ZERO_SKIP_EN
      if ((!o[1] && (x == '0 || y == '0)) || (o[1] && y == '0)) lat = 1;
`endif
      e.op       = o;
      e.a        = x;
      e.b        = y;
      e.done_cyc = cyc + lat;
      q.push_back(e);
      m_s = cyc;
      m_d = cyc + lat;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= m_d && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL wait_idle cyc=%0d got=still_busy required=idle", cyc);
    end
  endtask

  task automatic do_reset(input logic with_start);
    rst   = 1'b1;
    start = with_start;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    q.delete();
    m_s    = -100;
    m_d    = -100;
    reg_hi = '0;
    reg_lo = '0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: per-cycle busy/stall expectations plus scoreboard pop on done.
  always @(negedge clk) begin
    logic eb, es;
    if (chk_en) begin
      eb = (cyc > m_s) && (cyc <= m_d);
      es = (ID_mfhilo | ID_muldiv) & (start | ((cyc > m_s) && (cyc < m_d)));
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, eb);
      end
      total++;
      if ({pc_stall, IFID_stall, IDEX_flush} !== {3{es}}) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%b%b%b required=%b", cyc, pc_stall, IFID_stall, IDEX_flush, es);
      end
      if (done === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d got=done required=no_done", cyc);
        end else begin
          mon_e = q.pop_front();
          if (cyc != mon_e.done_cyc) begin
            bad++;
            $display("FAIL latency cyc=%0d got=%0d required=%0d", cyc, cyc, mon_e.done_cyc);
          end
          total++;
          if (hi !== mon_e.hi) begin
            bad++;
            $display("FAIL hi op=%0d a=%h b=%h got=%h required=%h", mon_e.op, mon_e.a, mon_e.b, hi, mon_e.hi);
          end
          total++;
          if (lo !== mon_e.lo) begin
            bad++;
            $display("FAIL lo op=%0d a=%h b=%h got=%h required=%h", mon_e.op, mon_e.a, mon_e.b, lo, mon_e.lo);
          end
          reg_hi = mon_e.hi;
          reg_lo = mon_e.lo;
          $display("txn cyc=%0d op=%0d a=%h b=%h hi=%h lo=%h", cyc, mon_e.op, mon_e.a, mon_e.b, hi, lo);
        end
      end else begin
        total++;
        if ({hi, lo} !== {reg_hi, reg_lo}) begin
          bad++;
          $display("FAIL hilo_hold cyc=%0d got=%h_%h required=%h_%h", cyc, hi, lo, reg_hi, reg_lo);
        end
        if (q.size() > 0 && cyc > q[0].done_cyc) begin
          total++;
          bad++;
          mon_e = q.pop_front();
          $display("FAIL done_timeout cyc=%0d got=no_done required=done_at_%0d", cyc, mon_e.done_cyc);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] x, y;
    logic [1:0]   o;

    tick();
    tick();
    do_reset(1'b0);
    chk_en = 1'b1;
    tick();
    tick();

    // Directed cases from the arithmetic corners.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);         wait_idle();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);         wait_idle();
    issue(2'd3, 32'd100, 32'd0);               wait_idle();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(2'd2, 32'hFFFF_FFFB, 32'd0);         wait_idle();
    issue(2'd0, 32'd0, 32'h1234_5678);         wait_idle();

    // MULT with a dependent MFHI in ID the same cycle.
    ID_mfhilo = 1'b1;
    issue(2'd0, 32'h0001_2345, 32'hFFFF_0003);
    wait_idle();
    ID_mfhilo = 1'b0;

    // MFHI while idle: no stall expected.
    ID_mfhilo = 1'b1;
    tick(); tick(); tick();
    ID_mfhilo = 1'b0;

    // Dependent muldiv in ID while busy, plus a stray start that must be ignored.
    issue(2'd1, 32'hDEAD_BEEF, 32'h0000_1001);
    tick(); tick(); tick();
    ID_muldiv = 1'b1;
    issue(2'd3, 32'h5555_5555, 32'd3);
    tick();
    ID_muldiv = 1'b0;
    wait_idle();

    // Reset ten cycles into a divide, then a clean operation.
    issue(2'd2, 32'h7654_3210, 32'd13);
    for (int i = 0; i < 9; i++) tick();
    do_reset(1'b0);
    tick();
    issue(2'd3, 32'hFFFF_0000, 32'd255); wait_idle();

    // Reset and start together: reset wins.
    ID_mfhilo = 1'b1;
    op = 2'd0; a = 32'd5; b = 32'd6;
    do_reset(1'b1);
    ID_mfhilo = 1'b0;
    tick(); tick();

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom_range(0, 3));
      x = rnd_opnd();
      y = rnd_opnd();
      ID_mfhilo = 1'($urandom_range(0, 1));
      issue(o, x, y);
      wait_idle();
      ID_mfhilo = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    tick(); tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d_pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
